// File: rtl/msrv32_dec_pipe.sv
// RV32I/Zicsr decoder with optional RV32M, one-cycle registered output stage
// and an optional 2-entry skid buffer. Also keeps a saturating illegal-instruction count.
module msrv32_dec_pipe #(
    parameter bit          EN_M_EXT = 1'b1,
    parameter bit          SKID     = 1'b1,
    parameter int unsigned CNT_W    = 32'd16
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic [31:0]      instr_in,
    input  logic [1:0]       iadder_1_to_0_in,
    input  logic             in_valid_in,
    output logic             in_ready_out,
    input  logic             out_ready_in,
    output logic             out_valid_out,
    input  logic             flush_in,
    input  logic             trap_taken_in,
    output logic [3:0]       alu_opcode_out,
    output logic             mem_wr_req_out,
    output logic [1:0]       load_size_out,
    output logic             load_unsigned_out,
    output logic             alu_src_out,
    output logic             iadder_src_out,
    output logic             csr_wr_en_out,
    output logic             rf_wr_en_out,
    output logic [2:0]       wb_mux_sel_out,
    output logic [2:0]       imm_type_out,
    output logic [2:0]       csr_op_out,
    output logic             illegal_instr_out,
    output logic             misaligned_load_out,
    output logic             misaligned_store_out,
    output logic             muldiv_en_out,
    output logic [2:0]       muldiv_op_out,
    output logic [CNT_W-1:0] illegal_cnt_out
);

    typedef struct packed {
        logic [3:0] alu_opcode;
        logic       mem_wr_req;
        logic [1:0] load_size;
        logic       load_unsigned;
        logic       alu_src;
        logic       iadder_src;
        logic       csr_wr_en;
        logic       rf_wr_en;
        logic [2:0] wb_mux_sel;
        logic [2:0] imm_type;
        logic [2:0] csr_op;
        logic       illegal;
        logic       mis_load;
        logic       mis_store;
        logic       muldiv_en;
        logic [2:0] muldiv_op;
    } bundle_t;

    logic [6:0] opcode_s;
    logic [2:0] funct3_s;
    logic       funct7_5_s;
    logic       is_op_s, is_op_imm_s, is_load_s, is_store_s, is_branch_s;
    logic       is_jal_s, is_jalr_s, is_lui_s, is_auipc_s, is_misc_mem_s, is_system_s;
    logic       is_m_s, is_csr_s, is_impl_s, mal_word_s, mal_half_s;
    logic       unused_s;
    bundle_t    dec_s;
    bundle_t    out_r;
    logic       out_valid_r;
    logic       take_in_s;
    logic       take_out_s;
    logic [CNT_W-1:0] cnt_r;

    assign opcode_s      = instr_in[6:0];
    assign funct3_s      = instr_in[14:12];
    assign funct7_5_s    = instr_in[30];
    assign unused_s      = ^{instr_in[24:15], instr_in[11:7]};

    assign is_op_s       = (opcode_s[6:2] == 5'b01100);
    assign is_op_imm_s   = (opcode_s[6:2] == 5'b00100);
    assign is_load_s     = (opcode_s[6:2] == 5'b00000);
    assign is_store_s    = (opcode_s[6:2] == 5'b01000);
    assign is_branch_s   = (opcode_s[6:2] == 5'b11000);
    assign is_jal_s      = (opcode_s[6:2] == 5'b11011);
    assign is_jalr_s     = (opcode_s[6:2] == 5'b11001);
    assign is_lui_s      = (opcode_s[6:2] == 5'b01101);
    assign is_auipc_s    = (opcode_s[6:2] == 5'b00101);
    assign is_misc_mem_s = (opcode_s[6:2] == 5'b00011);
    assign is_system_s   = (opcode_s[6:2] == 5'b11100);
    assign is_m_s        = is_op_s & (instr_in[31:25] == 7'b0000001);
    assign is_csr_s      = is_system_s & (|funct3_s);
    assign is_impl_s     = is_op_s | is_op_imm_s | is_load_s | is_store_s | is_branch_s |
                           is_jal_s | is_jalr_s | is_lui_s | is_auipc_s | is_misc_mem_s |
                           is_system_s;
    // Word access needs both low address bits clear, halfword only bit 0.
    assign mal_word_s    = funct3_s[1] & ~funct3_s[0] & (|iadder_1_to_0_in);
    assign mal_half_s    = ~funct3_s[1] & funct3_s[0] & iadder_1_to_0_in[0];

    // Combinational decode of the incoming instruction, trap-gated write enables.
    always_comb begin
        dec_s               = '0;
        dec_s.alu_opcode    = {funct7_5_s & ~(is_op_imm_s & (funct3_s[1:0] != 2'b01)), funct3_s};
        dec_s.mem_wr_req    = is_store_s & ~trap_taken_in;
        dec_s.load_size     = funct3_s[1:0];
        dec_s.load_unsigned = funct3_s[2];
        dec_s.alu_src       = opcode_s[5];
        dec_s.iadder_src    = is_load_s | is_store_s | is_jalr_s;
        dec_s.csr_wr_en     = is_csr_s & ~trap_taken_in;
        dec_s.rf_wr_en      = (is_lui_s | is_auipc_s | is_jalr_s | is_jal_s | is_op_s |
                               is_load_s | is_csr_s | is_op_imm_s) & ~trap_taken_in;
        dec_s.wb_mux_sel    = {is_csr_s | is_jal_s | is_jalr_s,
                               is_lui_s | is_auipc_s,
                               is_load_s | is_auipc_s | is_jal_s | is_jalr_s};
        dec_s.imm_type      = {is_lui_s | is_auipc_s | is_jal_s | is_csr_s,
                               is_store_s | is_branch_s | is_csr_s,
                               is_op_imm_s | is_load_s | is_jalr_s | is_branch_s | is_jal_s};
        dec_s.csr_op        = funct3_s;
        dec_s.illegal       = ~(&opcode_s[1:0]) | ~is_impl_s | (is_m_s & ~EN_M_EXT);
        dec_s.mis_load      = is_load_s & (mal_word_s | mal_half_s);
        dec_s.mis_store     = is_store_s & (mal_word_s | mal_half_s);
        dec_s.muldiv_en     = is_m_s & EN_M_EXT;
        dec_s.muldiv_op     = (is_m_s & EN_M_EXT) ? funct3_s : 3'b000;
    end

    assign take_in_s  = in_valid_in & in_ready_out;
    assign take_out_s = out_valid_r & out_ready_in;

    if (SKID) begin : g_skid
        bundle_t skid_r;
        logic    skid_valid_r;
        logic    in_ready_r;

        // Output register plus skid entry; the skid drains first so order is kept.
        always_ff @(posedge clk_in) begin
            if (rst_in) begin
                out_r        <= '0;
                out_valid_r  <= 1'b0;
                skid_r       <= '0;
                skid_valid_r <= 1'b0;
                in_ready_r   <= 1'b1;
            end else if (flush_in) begin
                out_valid_r  <= 1'b0;
                skid_valid_r <= 1'b0;
                in_ready_r   <= 1'b1;
            end else if (!out_valid_r || out_ready_in) begin
                if (skid_valid_r) begin
                    out_r        <= skid_r;
                    out_valid_r  <= 1'b1;
                    skid_valid_r <= 1'b0;
                    in_ready_r   <= 1'b1;
                end else if (take_in_s) begin
                    out_r       <= dec_s;
                    out_valid_r <= 1'b1;
                end else begin
                    out_valid_r <= 1'b0;
                end
            end else if (take_in_s) begin
                skid_r       <= dec_s;
                skid_valid_r <= 1'b1;
                in_ready_r   <= 1'b0;
            end
        end

        // The register reset value means "empty", so mask it while reset is held.
        assign in_ready_out = in_ready_r & ~rst_in;
    end else begin : g_single
        // Single output register that reloads whenever it is empty or draining.
        always_ff @(posedge clk_in) begin
            if (rst_in) begin
                out_r       <= '0;
                out_valid_r <= 1'b0;
            end else if (flush_in) begin
                out_valid_r <= 1'b0;
            end else if (!out_valid_r || out_ready_in) begin
                out_valid_r <= take_in_s;
                if (take_in_s) begin
                    out_r <= dec_s;
                end
            end
        end

        assign in_ready_out = (~out_valid_r | out_ready_in) & ~rst_in;
    end

    // Saturating count of illegal entries actually handed downstream.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cnt_r <= '0;
        end else if (!flush_in && take_out_s && out_r.illegal && (cnt_r != {CNT_W{1'b1}})) begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign out_valid_out        = out_valid_r;
    assign alu_opcode_out       = out_r.alu_opcode;
    assign mem_wr_req_out       = out_r.mem_wr_req;
    assign load_size_out        = out_r.load_size;
    assign load_unsigned_out    = out_r.load_unsigned;
    assign alu_src_out          = out_r.alu_src;
    assign iadder_src_out       = out_r.iadder_src;
    assign csr_wr_en_out        = out_r.csr_wr_en;
    assign rf_wr_en_out         = out_r.rf_wr_en;
    assign wb_mux_sel_out       = out_r.wb_mux_sel;
    assign imm_type_out         = out_r.imm_type;
    assign csr_op_out           = out_r.csr_op;
    assign illegal_instr_out    = out_r.illegal;
    assign misaligned_load_out  = out_r.mis_load;
    assign misaligned_store_out = out_r.mis_store;
    assign muldiv_en_out        = out_r.muldiv_en;
    assign muldiv_op_out        = out_r.muldiv_op;
    assign illegal_cnt_out      = cnt_r;

endmodule

// File: tb/tb_msrv32_dec_pipe.sv
// Bench for msrv32_dec_pipe: a default instance (M, skid, 16-bit count) and a
// reduced instance (no M, single register, 2-bit count) checked against a FIFO model.
module tb_msrv32_dec_pipe;

    typedef struct packed {
        logic [3:0] alu_opcode;
        logic       mem_wr_req;
        logic [1:0] load_size;
        logic       load_unsigned;
        logic       alu_src;
        logic       iadder_src;
        logic       csr_wr_en;
        logic       rf_wr_en;
        logic [2:0] wb_mux_sel;
        logic [2:0] imm_type;
        logic [2:0] csr_op;
        logic       illegal;
        logic       mis_load;
        logic       mis_store;
        logic       muldiv_en;
        logic [2:0] muldiv_op;
    } bundle_t;

    localparam logic [31:0] I_ADD = 32'h003100B3;
    localparam logic [31:0] I_MUL = 32'h023100B3;
    localparam logic [31:0] I_LW  = 32'h00012083;
    localparam logic [31:0] I_SW  = 32'h00112023;

    logic        clk, rst, in_valid, out_ready, flush, trap;
    logic [31:0] instr;
    logic [1:0]  iadder;

    logic in_ready0, out_valid0, mem_wr_req0, load_unsigned0, alu_src0, iadder_src0;
    logic csr_wr_en0, rf_wr_en0, illegal0, mis_load0, mis_store0, muldiv_en0;
    logic [3:0] alu_opcode0; logic [1:0] load_size0;
    logic [2:0] wb_mux_sel0, imm_type0, csr_op0, muldiv_op0;
    logic [15:0] cnt0;
    logic in_ready1, out_valid1, mem_wr_req1, load_unsigned1, alu_src1, iadder_src1;
    logic csr_wr_en1, rf_wr_en1, illegal1, mis_load1, mis_store1, muldiv_en1;
    logic [3:0] alu_opcode1; logic [1:0] load_size1;
    logic [2:0] wb_mux_sel1, imm_type1, csr_op1, muldiv_op1;
    logic [1:0] cnt1;
    bundle_t act0, act1;

    bundle_t q0[$];
    bundle_t q1[$];
    int      mcnt0, mcnt1;
    int      checks, errors;

    assign act0 = {alu_opcode0, mem_wr_req0, load_size0, load_unsigned0, alu_src0, iadder_src0,
                   csr_wr_en0, rf_wr_en0, wb_mux_sel0, imm_type0, csr_op0, illegal0,
                   mis_load0, mis_store0, muldiv_en0, muldiv_op0};
    assign act1 = {alu_opcode1, mem_wr_req1, load_size1, load_unsigned1, alu_src1, iadder_src1,
                   csr_wr_en1, rf_wr_en1, wb_mux_sel1, imm_type1, csr_op1, illegal1,
                   mis_load1, mis_store1, muldiv_en1, muldiv_op1};

    msrv32_dec_pipe #(.EN_M_EXT(1'b1), .SKID(1'b1), .CNT_W(32'd16)) dut0 (
        .clk_in(clk), .rst_in(rst), .instr_in(instr), .iadder_1_to_0_in(iadder),
        .in_valid_in(in_valid), .in_ready_out(in_ready0), .out_ready_in(out_ready),
        .out_valid_out(out_valid0), .flush_in(flush), .trap_taken_in(trap),
        .alu_opcode_out(alu_opcode0), .mem_wr_req_out(mem_wr_req0), .load_size_out(load_size0),
        .load_unsigned_out(load_unsigned0), .alu_src_out(alu_src0), .iadder_src_out(iadder_src0),
        .csr_wr_en_out(csr_wr_en0), .rf_wr_en_out(rf_wr_en0), .wb_mux_sel_out(wb_mux_sel0),
        .imm_type_out(imm_type0), .csr_op_out(csr_op0), .illegal_instr_out(illegal0),
        .misaligned_load_out(mis_load0), .misaligned_store_out(mis_store0),
        .muldiv_en_out(muldiv_en0), .muldiv_op_out(muldiv_op0), .illegal_cnt_out(cnt0));

    msrv32_dec_pipe #(.EN_M_EXT(1'b0), .SKID(1'b0), .CNT_W(32'd2)) dut1 (
        .clk_in(clk), .rst_in(rst), .instr_in(instr), .iadder_1_to_0_in(iadder),
        .in_valid_in(in_valid), .in_ready_out(in_ready1), .out_ready_in(out_ready),
        .out_valid_out(out_valid1), .flush_in(flush), .trap_taken_in(trap),
        .alu_opcode_out(alu_opcode1), .mem_wr_req_out(mem_wr_req1), .load_size_out(load_size1),
        .load_unsigned_out(load_unsigned1), .alu_src_out(alu_src1), .iadder_src_out(iadder_src1),
        .csr_wr_en_out(csr_wr_en1), .rf_wr_en_out(rf_wr_en1), .wb_mux_sel_out(wb_mux_sel1),
        .imm_type_out(imm_type1), .csr_op_out(csr_op1), .illegal_instr_out(illegal1),
        .misaligned_load_out(mis_load1), .misaligned_store_out(mis_store1),
        .muldiv_en_out(muldiv_en1), .muldiv_op_out(muldiv_op1), .illegal_cnt_out(cnt1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference decode written per instruction class.
    function automatic bundle_t ref_decode(logic [31:0] ins, logic [1:0] ia, logic tr, bit en_m);
        bundle_t    b;
        logic [2:0] f3;
        bit         legal;
        bit         mis;
        b     = '0;
        f3    = ins[14:12];
        legal = 1'b1;
        mis   = (f3[1:0] == 2'b10 && ia != 2'b00) || (f3[1:0] == 2'b01 && ia[0]);
        b.alu_opcode    = {ins[30], f3};
        b.load_size     = f3[1:0];
        b.load_unsigned = f3[2];
        b.alu_src       = ins[5];
        b.csr_op        = f3;
        case (ins[6:2])
            5'b01100: begin
                b.rf_wr_en = 1'b1;
                if (ins[31:25] == 7'b0000001) begin
                    if (en_m) begin b.muldiv_en = 1'b1; b.muldiv_op = f3; end
                    else legal = 1'b0;
                end
            end
            5'b00100: begin
                b.rf_wr_en = 1'b1; b.imm_type = 3'b001;
                if (f3 != 3'b001 && f3 != 3'b101) b.alu_opcode[3] = 1'b0;
            end
            5'b00000: begin
                b.rf_wr_en = 1'b1; b.wb_mux_sel = 3'b001; b.imm_type = 3'b001;
                b.iadder_src = 1'b1; b.mis_load = mis;
            end
            5'b01000: begin
                b.mem_wr_req = 1'b1; b.imm_type = 3'b010; b.iadder_src = 1'b1; b.mis_store = mis;
            end
            5'b11000: b.imm_type = 3'b011;
            5'b11011: begin b.rf_wr_en = 1'b1; b.wb_mux_sel = 3'b101; b.imm_type = 3'b101; end
            5'b11001: begin
                b.rf_wr_en = 1'b1; b.wb_mux_sel = 3'b101; b.imm_type = 3'b001; b.iadder_src = 1'b1;
            end
            5'b01101: begin b.rf_wr_en = 1'b1; b.wb_mux_sel = 3'b010; b.imm_type = 3'b100; end
            5'b00101: begin b.rf_wr_en = 1'b1; b.wb_mux_sel = 3'b011; b.imm_type = 3'b100; end
            5'b00011: legal = 1'b1;
            5'b11100: begin
                if (f3 != 3'b000) begin
                    b.csr_wr_en = 1'b1; b.rf_wr_en = 1'b1; b.wb_mux_sel = 3'b100; b.imm_type = 3'b110;
                end
            end
            default: legal = 1'b0;
        endcase
        b.illegal = !legal || (ins[1:0] != 2'b11);
        if (tr) begin b.mem_wr_req = 1'b0; b.csr_wr_en = 1'b0; b.rf_wr_en = 1'b0; end
        return b;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [6:0]  ops [11] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                                  7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b0001111,
                                  7'b1110011};
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 9))
            0: ;
            1: begin r[31:25] = 7'b0000001; r[6:0] = 7'b0110011; end
            default: r[6:0] = ops[$urandom_range(0, 10)];
        endcase
        return r;
    endfunction

    // One clock: model handshakes decided from model occupancy, then advance both models.
    task automatic cycle();
        bit ti0, ti1, to0, to1;
        ti0 = in_valid && !rst && (q0.size() < 2);
        ti1 = in_valid && !rst && (q1.size() == 0 || out_ready);
        to0 = (q0.size() > 0) && out_ready;
        to1 = (q1.size() > 0) && out_ready;
        @(posedge clk);
        if (rst) begin
            q0.delete(); q1.delete(); mcnt0 = 0; mcnt1 = 0;
        end else if (flush) begin
            q0.delete(); q1.delete();
        end else begin
            if (to0) begin
                if (q0[0].illegal && mcnt0 < 65535) mcnt0++;
                void'(q0.pop_front());
            end
            if (to1) begin
                if (q1[0].illegal && mcnt1 < 3) mcnt1++;
                void'(q1.pop_front());
            end
            if (ti0) q0.push_back(ref_decode(instr, iadder, trap, 1'b1));
            if (ti1) q1.push_back(ref_decode(instr, iadder, trap, 1'b0));
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; instr = I_ADD; out_ready = 1'b0;
        repeat (3) cycle();
        checks++;
        if (out_valid0 !== 1'b0 || in_ready0 !== 1'b0 || act0 !== '0 || cnt0 !== 16'd0 ||
            out_valid1 !== 1'b0 || in_ready1 !== 1'b0 || act1 !== '0 || cnt1 !== 2'd0) begin
            errors++;
            $display("FAIL reset_state: v0=%b r0=%b b0=%h c0=%0d v1=%b r1=%b b1=%h c1=%0d, required all 0",
                     out_valid0, in_ready0, act0, cnt0, out_valid1, in_ready1, act1, cnt1);
        end
        rst = 1'b0; in_valid = 1'b0;
        #1;
        checks++;
        if (in_ready0 !== 1'b1 || in_ready1 !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset: r0=%b r1=%b, required 1 1", in_ready0, in_ready1);
        end
    endtask

    task automatic test_add();
        in_valid = 1'b1; instr = I_ADD; out_ready = 1'b1;
        cycle();
        in_valid = 1'b0;
        checks++;
        if (out_valid0 !== 1'b1 || rf_wr_en0 !== 1'b1 || alu_src0 !== 1'b1 ||
            illegal0 !== 1'b0 || muldiv_en0 !== 1'b0) begin
            errors++;
            $display("FAIL add_fields: v=%b rf=%b src=%b ill=%b md=%b, required 1 1 1 0 0",
                     out_valid0, rf_wr_en0, alu_src0, illegal0, muldiv_en0);
        end
        checks++;
        if (act0 !== ref_decode(I_ADD, 2'b00, 1'b0, 1'b1) || act1 !== ref_decode(I_ADD, 2'b00, 1'b0, 1'b0)) begin
            errors++;
            $display("FAIL add_bundle: got %h/%h, required %h/%h", act0, act1,
                     ref_decode(I_ADD, 2'b00, 1'b0, 1'b1), ref_decode(I_ADD, 2'b00, 1'b0, 1'b0));
        end
        cycle();
    endtask

    task automatic test_mul();
        in_valid = 1'b1; instr = I_MUL; out_ready = 1'b0;
        cycle();
        in_valid = 1'b0;
        checks++;
        if (muldiv_en0 !== 1'b1 || muldiv_op0 !== 3'b000 || illegal0 !== 1'b0 || wb_mux_sel0 !== 3'b000) begin
            errors++;
            $display("FAIL mul_m_on: md=%b op=%b ill=%b wb=%b, required 1 000 0 000",
                     muldiv_en0, muldiv_op0, illegal0, wb_mux_sel0);
        end
        checks++;
        if (illegal1 !== 1'b1 || muldiv_en1 !== 1'b0 || cnt1 !== 2'd0) begin
            errors++;
            $display("FAIL mul_m_off: ill=%b md=%b cnt=%0d, required 1 0 0", illegal1, muldiv_en1, cnt1);
        end
        out_ready = 1'b1;
        cycle();
        checks++;
        if (cnt1 !== 2'd1 || cnt0 !== 16'd0 || out_valid1 !== 1'b0) begin
            errors++;
            $display("FAIL mul_count: cnt1=%0d cnt0=%0d v1=%b, required 1 0 0", cnt1, cnt0, out_valid1);
        end
    endtask

    task automatic test_skid();
        logic [31:0] seq [3] = '{32'h00500093, I_ADD, 32'h40310133};
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; instr = seq[i];
            cycle();
        end
        in_valid = 1'b0;
        checks++;
        if (in_ready0 !== 1'b0 || out_valid0 !== 1'b1 || act0 !== ref_decode(seq[0], 2'b00, 1'b0, 1'b1)) begin
            errors++;
            $display("FAIL skid_full: r=%b v=%b b=%h, required 0 1 %h", in_ready0, out_valid0, act0,
                     ref_decode(seq[0], 2'b00, 1'b0, 1'b1));
        end
        out_ready = 1'b1;
        cycle();
        checks++;
        if (out_valid0 !== 1'b1 || act0 !== ref_decode(seq[1], 2'b00, 1'b0, 1'b1) || in_ready0 !== 1'b1) begin
            errors++;
            $display("FAIL skid_order: v=%b b=%h r=%b, required 1 %h 1", out_valid0, act0, in_ready0,
                     ref_decode(seq[1], 2'b00, 1'b0, 1'b1));
        end
        cycle();
        checks++;
        if (out_valid0 !== 1'b0) begin
            errors++;
            $display("FAIL skid_drain: v=%b, required 0", out_valid0);
        end
    endtask

    task automatic test_trap();
        in_valid = 1'b1; instr = I_LW; iadder = 2'b10; trap = 1'b1; out_ready = 1'b1;
        cycle();
        checks++;
        if (mis_load0 !== 1'b1 || rf_wr_en0 !== 1'b0 || act0 !== ref_decode(I_LW, 2'b10, 1'b1, 1'b1)) begin
            errors++;
            $display("FAIL trap_lw: mis=%b rf=%b b=%h, required 1 0", mis_load0, rf_wr_en0, act0);
        end
        instr = I_SW; iadder = 2'b01;
        cycle();
        checks++;
        if (mis_store0 !== 1'b1 || mem_wr_req0 !== 1'b0 || act1 !== ref_decode(I_SW, 2'b01, 1'b1, 1'b0)) begin
            errors++;
            $display("FAIL trap_sw: mis=%b wr=%b b1=%h, required 1 0", mis_store0, mem_wr_req0, act1);
        end
        in_valid = 1'b0; trap = 1'b0; iadder = 2'b00;
        cycle();
    endtask

    task automatic test_flush();
        int saved0, saved1;
        out_ready = 1'b0; in_valid = 1'b1; instr = 32'h0;
        cycle(); cycle();
        saved0 = mcnt0; saved1 = mcnt1;
        checks++;
        if (in_ready0 !== 1'b0 || out_valid0 !== 1'b1) begin
            errors++;
            $display("FAIL flush_setup: r=%b v=%b, required 0 1", in_ready0, out_valid0);
        end
        flush = 1'b1; instr = I_ADD; out_ready = 1'b1;
        cycle();
        flush = 1'b0; in_valid = 1'b0;
        checks++;
        if (out_valid0 !== 1'b0 || out_valid1 !== 1'b0 || cnt0 !== 16'(saved0) || cnt1 !== 2'(saved1)) begin
            errors++;
            $display("FAIL flush: v0=%b v1=%b c0=%0d c1=%0d, required 0 0 %0d %0d",
                     out_valid0, out_valid1, cnt0, cnt1, saved0, saved1);
        end
        cycle();
        checks++;
        if (out_valid0 !== 1'b0 || in_ready0 !== 1'b1) begin
            errors++;
            $display("FAIL flush_drop: v=%b r=%b, required 0 1", out_valid0, in_ready0);
        end
    endtask

    task automatic test_cnt_sat();
        rst = 1'b1; cycle(); rst = 1'b0;
        out_ready = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            instr = $urandom & 32'hFFFF_FFFC;
            cycle();
        end
        in_valid = 1'b0;
        cycle();
        checks++;
        if (cnt1 !== 2'd3 || cnt0 !== 16'd5) begin
            errors++;
            $display("FAIL cnt_sat: cnt1=%0d cnt0=%0d, required 3 5", cnt1, cnt0);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            rst       = ($urandom_range(0, 99) == 0);
            flush     = ($urandom_range(0, 19) == 0);
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            trap      = ($urandom_range(0, 4) == 0);
            iadder    = 2'($urandom);
            instr     = rand_instr();
            cycle();
            checks++;
            if (out_valid0 !== (q0.size() > 0) || (q0.size() > 0 && act0 !== q0[0]) ||
                in_ready0 !== (!rst && q0.size() < 2) || cnt0 !== 16'(mcnt0)) begin
                errors++;
                $display("FAIL random_dut0 n=%0d: v=%b b=%h r=%b c=%0d, required v=%b b=%h r=%b c=%0d",
                         n, out_valid0, act0, in_ready0, cnt0, q0.size() > 0,
                         (q0.size() > 0) ? q0[0] : bundle_t'('0), !rst && q0.size() < 2, mcnt0);
            end
            checks++;
            if (out_valid1 !== (q1.size() > 0) || (q1.size() > 0 && act1 !== q1[0]) ||
                in_ready1 !== (!rst && (q1.size() == 0 || out_ready)) || cnt1 !== 2'(mcnt1)) begin
                errors++;
                $display("FAIL random_dut1 n=%0d: v=%b b=%h r=%b c=%0d, required v=%b b=%h c=%0d",
                         n, out_valid1, act1, in_ready1, cnt1, q1.size() > 0,
                         (q1.size() > 0) ? q1[0] : bundle_t'('0), mcnt1);
            end
        end
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; trap = 1'b0;
    endtask

    initial begin
        checks = 0; errors = 0; mcnt0 = 0; mcnt1 = 0;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; trap = 1'b0;
        instr = 32'h0; iadder = 2'b00;
        test_reset();
        test_add();
        test_mul();
        test_skid();
        test_trap();
        test_flush();
        test_cnt_sat();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/msrv32_dec_pipe.md
MSRV32_DEC_PIPE -- requirements
Module: msrv32_dec_pipe

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset; no other clock or reset SHALL exist.
REQ-002 Parameter EN_M_EXT, default 1: when 1, RV32M (opcode 0110011, funct7 0000001) SHALL decode as legal.
REQ-003 Parameter SKID, default 1: when 1, a 2-entry skid buffer SHALL be used; when 0, a single output register SHALL be used.
REQ-004 Parameter CNT_W, default 16: width of the illegal-instruction counter.
REQ-005 Ports SHALL be:
- clk_in in 1: clock.
- rst_in in 1: synchronous active-high reset.
- instr_in in 32: fetched instruction.
- iadder_1_to_0_in in 2: low bits of the computed address.
- in_valid_in in 1: upstream data valid.
- in_ready_out out 1: block can accept.
- out_ready_in in 1: downstream can accept.
- out_valid_out out 1: decoded bundle valid.
- flush_in in 1: discard all held entries.
- trap_taken_in in 1: trap this cycle; suppress side effects.
- alu_opcode_out out 4; mem_wr_req_out out 1; load_size_out out 2; load_unsigned_out out 1; alu_src_out out 1; iadder_src_out out 1; csr_wr_en_out out 1; rf_wr_en_out out 1; wb_mux_sel_out out 3; imm_type_out out 3; csr_op_out out 3; illegal_instr_out out 1; misaligned_load_out out 1; misaligned_store_out out 1: registered decode bundle.
- muldiv_en_out out 1: entry is an RV32M operation.
- muldiv_op_out out 3: funct3 of the RV32M operation.
- illegal_cnt_out out CNT_W: saturating illegal-instruction count.

Function
REQ-006 The combinational decode of opcode/funct3/funct7[5] SHALL match the msrv32_dec field encodings for RV32I and Zicsr.
REQ-007 When EN_M_EXT=1 and the instruction is RV32M: muldiv_en=1, muldiv_op=funct3, rf_wr_en=1, illegal=0; wb_mux_sel SHALL be the ALU result code.
REQ-008 When EN_M_EXT=0, RV32M SHALL decode as illegal; muldiv_en SHALL be 0 for all non-RV32M instructions.
REQ-009 Transfer in SHALL occur when in_valid_in and in_ready_out are both high; transfer out SHALL occur when out_valid_out and out_ready_in are both high.
REQ-010 Latency SHALL be 1 cycle from transfer-in to out_valid_out.
REQ-011 SKID=1: in_ready_out SHALL be registered and high when the skid entry is empty; back-to-back throughput SHALL be 1 per cycle.
REQ-012 SKID=1: a transfer-in while the output is stalled SHALL be stored in the skid entry, and in_ready_out SHALL drop the next cycle.
REQ-013 SKID=1: the skid entry SHALL move to the output on the next transfer-out.
REQ-014 SKID=0: in_ready_out SHALL equal !out_valid_out || out_ready_in.
REQ-015 Output fields SHALL be held stable while out_valid_out=1 and out_ready_in=0.
REQ-016 Misaligned load: LW with iadder[1:0]!=0, or LH/LHU with iadder[0]=1, SHALL be computed at capture. Misaligned store SHALL use the same rule for SW/SH.
REQ-017 For an entry with trap_taken_in high at capture: mem_wr_req, csr_wr_en and rf_wr_en SHALL be registered as 0; the other fields SHALL be registered unchanged.
REQ-018 flush_in SHALL clear out_valid_out and the skid entry at the next edge; transfer-in in the same cycle SHALL be dropped; flush SHALL take priority over all handshakes.
REQ-019 illegal_cnt_out SHALL increment by 1 on each transfer-out with illegal_instr_out=1, SHALL saturate at 2^CNT_W-1, and SHALL not count flushed entries.

Reset
REQ-020 While rst_in is high at a clock edge, the following SHALL be 0 at that edge: out_valid_out, the skid entry valid, illegal_cnt_out, all bundle outputs, muldiv_en_out and muldiv_op_out.
REQ-021 During reset, in_ready_out SHALL be 0; it SHALL be 1 in the first cycle after reset deasserts.
REQ-022 Reset asserted mid-stall SHALL discard all entries without emitting them.

Verification
REQ-023 The bench SHALL cover ADD 0x003100B3 with in_valid=1 and out_ready=1: the next cycle gives out_valid=1, rf_wr_en=1, alu_src=1, illegal=0, muldiv_en=0.
REQ-024 The bench SHALL cover MUL 0x023100B3 with EN_M_EXT=1: muldiv_en=1 and muldiv_op=000. With EN_M_EXT=0 the same instruction gives illegal=1, and the counter reads 1 after transfer-out.
REQ-025 The bench SHALL cover SKID=1 with out_ready=0 and 3 valid instructions offered: 2 are accepted and in_ready=0. On out_ready=1 they emerge in order with no loss or duplication.
REQ-026 The bench SHALL cover LW with iadder=2'b10 and trap_taken=1: misaligned_load=1 and rf_wr_en=0. SW 0x00112023 with iadder=2'b01 gives misaligned_store=1 and mem_wr_req=0.
REQ-027 The bench SHALL cover flush_in asserted with both entries full and in_valid=1: out_valid=0 next cycle, and the counter is unchanged.
REQ-028 The bench SHALL cover CNT_W=2 with 5 illegal instructions transferred: illegal_cnt_out=3.
